// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data SRAM between the core and host ports, core has fixed priority, host starvation bounded by MAX_WAIT.
// Latency: gnt/strobes one cycle after the sampling edge; read data + rvalid two cycles after gnt; write 2 cycles, read 3 cycles per access.
// Backpressure: requesters hold req until gnt; the losing requester simply keeps req high and is re-arbitrated at the next IDLE.
// Ports: core_* and host_* request/grant/response pairs, mem_* SRAM strobes/addresses/data, busy = FSM not idle.
module dmem_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              owner_host;
  logic [3:0]        host_wait;

  // Host wins when the core is absent or the host has lost MAX_WAIT times in a row.
  logic              host_wins;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  always_comb begin
    host_wins = host_req && (!core_req || (host_wait == 4'(MAX_WAIT)));
    win_we    = core_we;
    win_addr  = core_addr;
    win_wdata = core_wdata;
    if (host_wins) begin
      win_we    = host_we;
      win_addr  = host_addr;
      win_wdata = host_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_host  <= 1'b0;
      host_wait   <= 4'd0;
      core_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      core_rdata  <= '0;
      host_rdata  <= '0;
    end else begin
      core_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req || host_req) begin
            we_q       <= win_we;
            addr_q     <= win_addr;
            wdata_q    <= win_wdata;
            owner_host <= host_wins;
            state      <= ISSUE;
            if (host_wins) begin
              host_wait <= 4'd0;
            end else if (host_req && (host_wait < 4'(MAX_WAIT))) begin
              host_wait <= host_wait + 4'd1;
            end
          end
        end
        ISSUE: state <= we_q ? IDLE : RESP;
        RESP: begin
          // SRAM read data is valid in this cycle; capture it at the exit edge.
          if (owner_host) begin
            host_rdata  <= mem_data_out;
            host_rvalid <= 1'b1;
          end else begin
            core_rdata  <= mem_data_out;
            core_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants and strobes decode straight from the state register, so there is
  // no combinational path from req to gnt.
  assign core_gnt     = (state == ISSUE) && !owner_host;
  assign host_gnt     = (state == ISSUE) &&  owner_host;
  assign mem_wren     = (state == ISSUE) &&  we_q;
  assign mem_rden     = (state == ISSUE) && !we_q;
  assign mem_addr_in  = addr_q;
  assign mem_addr_out = addr_q;
  assign mem_data_in  = wdata_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural 256x32 SRAM.
// Inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Covers reset, host write/read, core/host collision, starvation bound, and reset during RESP.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        core_req, core_we;
  logic [7:0]  core_addr;
  logic [31:0] core_wdata;
  logic        core_gnt, core_rvalid;
  logic [31:0] core_rdata;
  logic        host_req, host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_rden, mem_wren;
  logic [7:0]  mem_addr_in, mem_addr_out;
  logic [31:0] mem_data_in, mem_data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram [256];

  always #5 clock = ~clock;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(8), .MAX_WAIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr_in(mem_addr_in),
    .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  // SRAM model: one-cycle read latency.
  always @(posedge clock) begin
    if (mem_wren) sram[mem_addr_in] <= mem_data_in;
    if (mem_rden) mem_data_out <= sram[mem_addr_out];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  int core_before;
  int core_after;
  bit host_seen;

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[8'h20] = 32'h1234_5678;
    mem_data_out = 32'h0;

    // Reset with both requests active.
    reset_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h01; core_wdata = 32'h1111_1111;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h02; host_wdata = 32'h2222_2222;
    tick(); tick();
    smp();
    check("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
    check("rst_host_gnt", {31'd0, host_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, core_rvalid, host_rvalid}, 32'd0);
    check("rst_strobes", {30'd0, mem_rden, mem_wren}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {16'd0, mem_addr_in, mem_addr_out}, 32'd0);
    check("rst_wdata", mem_data_in, 32'd0);
    check("rst_core_rdata", core_rdata, 32'd0);
    check("rst_host_rdata", host_rdata, 32'd0);
    core_req = 1'b0; host_req = 1'b0; reset_n = 1'b1;
    tick();

    // Host write 0x10 <- DEADBEEF.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 32'hDEAD_BEEF;
    tick();
    host_req = 1'b0;
    smp();
    check("hw_host_gnt", {31'd0, host_gnt}, 32'd1);
    check("hw_core_gnt", {31'd0, core_gnt}, 32'd0);
    check("hw_wren", {30'd0, mem_wren, mem_rden}, 32'd2);
    check("hw_addr_in", {24'd0, mem_addr_in}, 32'h10);
    check("hw_data_in", mem_data_in, 32'hDEAD_BEEF);
    check("hw_busy", {31'd0, busy}, 32'd1);
    tick();
    smp();
    check("hw_idle", {30'd0, busy, host_gnt}, 32'd0);

    // Host read 0x10.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    tick();
    host_req = 1'b0;
    smp();
    check("hr_gnt_rden", {29'd0, host_gnt, mem_rden, mem_wren}, 32'd6);
    check("hr_addr_out", {24'd0, mem_addr_out}, 32'h10);
    tick();
    smp();
    check("hr_resp", {29'd0, busy, host_rvalid, mem_rden}, 32'd4);
    tick();
    smp();
    check("hr_rvalid", {29'd0, host_rvalid, core_rvalid, busy}, 32'd4);
    check("hr_rdata", host_rdata, 32'hDEAD_BEEF);
    tick();
    smp();
    check("hr_rvalid_pulse", {31'd0, host_rvalid}, 32'd0);
    check("hr_rdata_hold", host_rdata, 32'hDEAD_BEEF);

    // Collision: core read 0x20 vs host write 0x21.
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h21; host_wdata = 32'h5A5A_5A5A;
    tick();
    core_req = 1'b0;
    smp();
    check("col_core_first", {30'd0, core_gnt, host_gnt}, 32'd2);
    check("col_wait1", {28'd0, dut.host_wait}, 32'd1);
    tick();
    smp();
    check("col_resp_nognt", {30'd0, core_gnt, host_gnt}, 32'd0);
    tick();
    smp();
    check("col_core_rvalid", {30'd0, core_rvalid, host_rvalid}, 32'd2);
    check("col_core_rdata", core_rdata, 32'h1234_5678);
    check("col_host_rdata_kept", host_rdata, 32'hDEAD_BEEF);
    tick();
    host_req = 1'b0;
    smp();
    check("col_host_gnt", {30'd0, core_gnt, host_gnt}, 32'd1);
    check("col_host_wr", {29'd0, mem_wren, mem_rden, core_rvalid}, 32'd4);
    check("col_host_addr", {24'd0, mem_addr_in}, 32'h21);
    check("col_wait0", {28'd0, dut.host_wait}, 32'd0);
    tick();
    smp();
    check("col_sram", sram[8'h21], 32'h5A5A_5A5A);

    // Starvation: core back-to-back writes, host held until granted.
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h30; core_wdata = 32'hC0C0_0000;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h31; host_wdata = 32'hB0B0_0001;
    core_before = 0; core_after = 0; host_seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      smp();
      if (host_gnt) begin
        host_seen = 1'b1;
        host_req  = 1'b0;
        check("stv_wait_clear", {28'd0, dut.host_wait}, 32'd0);
      end
      if (core_gnt) begin
        if (host_seen) core_after++;
        else core_before++;
      end
    end
    core_req = 1'b0;
    check("stv_core_before", core_before, 32'd4);
    check("stv_host_served", {31'd0, host_seen}, 32'd1);
    check("stv_core_after", {31'd0, core_after > 0}, 32'd1);
    tick(); tick();
    smp();
    check("stv_idle", {31'd0, busy}, 32'd0);

    // Reset during RESP of a core read.
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
    tick();
    core_req = 1'b0;
    tick();
    reset_n = 1'b0;
    smp();
    check("rr_in_resp", {30'd0, busy, mem_rden}, 32'd2);
    tick();
    reset_n = 1'b1;
    smp();
    check("rr_no_rvalid", {30'd0, core_rvalid, busy}, 32'd0);
    check("rr_rdata_clr", core_rdata, 32'd0);
    tick();
    smp();
    check("rr_still_quiet", {29'd0, core_rvalid, host_rvalid, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the 256×32 data SRAM. The RISC-V core's load/store port and the external host debug/load port both need that SRAM. The block accepts one request at a time from either requester, drives the SRAM strobes and addresses, and returns read data with a per-requester valid pulse. Core requests have fixed priority. A wait counter bounds how long the host can be starved.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 8, SRAM address width
- MAX_WAIT, 4, consecutive lost arbitrations after which the host wins (1..15)

- clock  in  1  system clock, all logic on the rising edge
- reset_n  in  1  reset, synchronous, active-low
- core_req  in  1  core access request; hold until core_gnt seen
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  word address
- core_wdata  in  DATA_W  write data
- core_gnt  out  1  one-cycle pulse: request accepted, issuing
- core_rvalid  out  1  one-cycle pulse: core_rdata valid
- core_rdata  out  DATA_W  read data
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same as the core_* ports, for the host requester
- mem_rden  out  1  SRAM read enable
- mem_wren  out  1  SRAM write enable
- mem_addr_in  out  ADDR_W  SRAM write address
- mem_addr_out  out  ADDR_W  SRAM read address
- mem_data_in  out  DATA_W  SRAM write data
- mem_data_out  in  DATA_W  SRAM read data, valid in the cycle after mem_rden
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If either req is high, pick a winner.
  - Latch the winner's we, addr and wdata into we_q, addr_q and wdata_q, and record the owner.
  - Next state is ISSUE. With no requests, stay in IDLE.
- Arbitration:
  - The core wins by default.
  - The host wins if core_req is low, or if host_wait == MAX_WAIT.
- host_wait counter (4 bits):
  - Increments in any IDLE cycle with host_req=1 where the core wins.
  - Clears when the host wins.
  - Holds otherwise; it never exceeds MAX_WAIT.
- ISSUE:
  - Owner's gnt = 1.
  - mem_wren = we_q and mem_rden = ~we_q.
  - mem_addr_in = mem_addr_out = addr_q; mem_data_in = wdata_q.
  - Next state: IDLE for a write, RESP for a read.
- RESP:
  - All strobes are 0.
  - At the exit edge, capture mem_data_out into the owner's rdata register and set the owner's rvalid for one cycle.
  - Next state is IDLE.
- rdata registers hold their value until the next read for the same owner completes. rvalid is a one-cycle pulse.
- Requesters must deassert req (or present a new request) on the edge ending the gnt cycle. A req still high in IDLE after its gnt is treated as a new request.
- Address values are passed through unchanged, so no wrap or overflow logic is needed.
- The non-owner's gnt and rvalid are always 0.

## Timing
- Reset (reset_n=0 at an edge):
  - state = IDLE, host_wait = 0.
  - All gnt, rvalid, mem_rden, mem_wren and busy are 0.
  - mem_addr_*, mem_data_in and both rdata registers are 0.
- Reset mid-operation (in ISSUE or RESP): the access is abandoned, no rvalid pulse occurs, and the SRAM strobes drop in the next cycle.
- Let E0 be the edge that samples req in IDLE:
  - gnt and the strobes are high in the cycle after E0.
  - For a write: back to IDLE after E1; the next arbitration is at E2. Throughput is 1 write per 2 cycles.
  - For a read: RESP after E1; rvalid and rdata are valid in the cycle after E2, concurrent with IDLE. Throughput is 1 read per 3 cycles.
- Simultaneous core_req and host_req with host_wait < MAX_WAIT:
  - The core is served.
  - The host is served at the next IDLE unless core_req is high again.
- All outputs are registered or decoded from the state register. No combinational path exists from req to gnt.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with both reqs high -> all outputs 0, busy=0, no strobes.
- Host write then read:
  - Host writes addr 0x10, data 0xDEADBEEF -> host_gnt, mem_wren=1 and mem_addr_in=0x10 in the cycle after E0.
  - Host then reads 0x10 -> host_rvalid=1 with host_rdata=0xDEADBEEF in the cycle after E2 (bench SRAM model).
- Collision:
  - core_req (read 0x20) and host_req (write 0x21, 0x5A5A5A5A) rise together.
  - Required: core_gnt first; core_rvalid later with the SRAM's 0x20 contents; host_gnt at the following IDLE.
  - host_rvalid and core_rvalid are never high for the wrong owner.
- Starvation with MAX_WAIT=4:
  - core_req held high (back-to-back writes) and host_req held high.
  - Required: exactly 4 core grants, then host_gnt, host_wait returns to 0, and the core wins again afterward.
- Reset in RESP: assert reset_n=0 during the RESP of a core read -> core_rvalid stays 0, state IDLE, core_rdata = 0.
